// File: rtl/mem_pkg.sv
// mem_pkg: shared state encodings, word geometry and index-width helper
package mem_pkg;
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_RESP = 2'd2} state_t;
    localparam int WORD_BYTES = 4;
    localparam int CNT_W = 4;
    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/mem_wait_responder_if.sv
// mem_wait_responder_if: request/response handshake bundle between CPU memory port and responder
interface mem_wait_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    modport slave (input req_valid, req_write, req_addr, req_wdata, resp_ready,
                   output req_ready, resp_valid, resp_rdata, resp_err);
    modport master (output req_valid, req_write, req_addr, req_wdata, resp_ready,
                    input req_ready, resp_valid, resp_rdata, resp_err);
endinterface

// File: rtl/mem_word_array.sv
// mem_word_array: DEPTH x 32 word store, synchronous write, registered read with explicit clear
module mem_word_array
    import mem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int IW = clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_we,
    input  logic          i_re,
    input  logic          i_clr,
    input  logic [IW-1:0] i_idx,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);
    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
            r_rdata <= '0;
        end else begin
            if (i_we) r_mem[i_idx] <= i_wdata;
            if (i_re) r_rdata <= r_mem[i_idx];
            else if (i_clr) r_rdata <= '0;
        end
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/mem_wait_responder.sv
// mem_wait_responder: single-outstanding memory responder with programmable wait states
module mem_wait_responder
    import mem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int LATENCY = 2
) (
    input logic                 clk,
    input logic                 reset,
    mem_wait_responder_if.slave bus
);
    localparam int IW = clog2(DEPTH);

    if (LATENCY < 0 || LATENCY > 15) begin : g_bad_latency
        $error("LATENCY must be 0..15");
    end
    if (DEPTH < 2 || (1 << IW) != DEPTH) begin : g_bad_depth
        $error("DEPTH must be a power of 2 and >= 2");
    end

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_req_ready;
    logic             r_resp_valid;
    logic             r_resp_err;
    logic             r_write;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;

    logic             w_accept;
    logic             w_commit;
    logic             w_c_write;
    logic [31:0]      w_c_addr;
    logic [31:0]      w_c_wdata;
    logic             w_err;
    logic [31:0]      w_rdata;

    // With zero latency the commit edge is the accept edge, so use the live bus fields
    assign w_accept  = (r_state == ST_IDLE) && r_req_ready && bus.req_valid;
    assign w_commit  = ((r_state == ST_WAIT) && (r_cnt == 1)) || ((LATENCY == 0) && w_accept);
    assign w_c_write = (r_state == ST_IDLE) ? bus.req_write : r_write;
    assign w_c_addr  = (r_state == ST_IDLE) ? bus.req_addr  : r_addr;
    assign w_c_wdata = (r_state == ST_IDLE) ? bus.req_wdata : r_wdata;
    assign w_err     = (w_c_addr[1:0] != 2'b00) || (w_c_addr[31:2] >= 30'(DEPTH));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_req_ready  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_write      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_req_ready <= 1'b1;
                    if (w_accept) begin
                        r_write     <= bus.req_write;
                        r_addr      <= bus.req_addr;
                        r_wdata     <= bus.req_wdata;
                        r_req_ready <= 1'b0;
                        if (LATENCY == 0) begin
                            r_state      <= ST_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= w_err;
                        end else begin
                            r_state <= ST_WAIT;
                            r_cnt   <= CNT_W'(LATENCY);
                        end
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == 1) begin
                        r_state      <= ST_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= w_err;
                    end
                end
                ST_RESP: begin
                    if (bus.resp_ready) begin
                        r_state      <= ST_IDLE;
                        r_resp_valid <= 1'b0;
                        r_resp_err   <= 1'b0;
                        r_req_ready  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    mem_word_array #(.DEPTH(DEPTH), .IW(IW)) u_array (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_commit && w_c_write && !w_err),
        .i_re    (w_commit && !w_c_write && !w_err),
        .i_clr   ((r_state == ST_RESP) && bus.resp_ready),
        .i_idx   (w_c_addr[IW+1:2]),
        .i_wdata (w_c_wdata),
        .o_rdata (w_rdata)
    );

    assign bus.req_ready  = r_req_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_err   = r_resp_err;
    assign bus.resp_rdata = w_rdata;
endmodule

// File: tb/tb_mem_wait_responder.sv
// tb_mem_wait_responder: directed checks of a LATENCY=2 responder and a LATENCY=0 responder
module tb_mem_wait_responder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_wait_responder_if bus ();
    mem_wait_responder_if bus0 ();

    mem_wait_responder #(.DEPTH(256), .LATENCY(2)) dut (.clk(clk), .reset(rst_n), .bus(bus.slave));
    mem_wait_responder #(.DEPTH(256), .LATENCY(0)) dut0 (.clk(clk), .reset(rst_n), .bus(bus0.slave));

    // Drives one request on bus and returns at the first negedge after its accept edge
    task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!bus.req_ready) begin
            failures++;
            $display("FAIL accept_timeout addr=%h got_ready=%b exp=1", a, bus.req_ready);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    // Counts cycles from the accept edge until resp_valid, bounded
    task automatic wait_resp(output int lat);
        lat = 1;
        while (!bus.resp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic ack();
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        int lat;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b0 || bus.resp_rdata !== 32'h0 || bus.resp_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got ready=%b valid=%b rdata=%h err=%b exp 0/0/0/0",
                     bus.req_ready, bus.resp_valid, bus.resp_rdata, bus.resp_err);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_reset got=%b exp=1", bus.req_ready);
        end
        send(1'b0, 32'h0000_0010, 32'h0);
        wait_resp(lat);
        checks++;
        if (lat != 3) begin
            failures++;
            $display("FAIL read_latency got=%0d exp=3", lat);
        end
        checks++;
        if (bus.resp_rdata !== 32'h0 || bus.resp_err !== 1'b0) begin
            failures++;
            $display("FAIL first_read got rdata=%h err=%b exp 0/0", bus.resp_rdata, bus.resp_err);
        end
        ack();
    endtask

    task automatic test_write_read();
        int lat;
        send(1'b1, 32'h0000_0008, 32'hDEAD_BEEF);
        wait_resp(lat);
        checks++;
        if (lat != 3 || bus.resp_rdata !== 32'h0 || bus.resp_err !== 1'b0) begin
            failures++;
            $display("FAIL write_resp got lat=%0d rdata=%h err=%b exp 3/0/0", lat, bus.resp_rdata, bus.resp_err);
        end
        ack();
        send(1'b0, 32'h0000_0008, 32'h0);
        wait_resp(lat);
        checks++;
        if (bus.resp_rdata !== 32'hDEAD_BEEF || bus.resp_err !== 1'b0) begin
            failures++;
            $display("FAIL read_back got rdata=%h err=%b exp deadbeef/0", bus.resp_rdata, bus.resp_err);
        end
        ack();
    endtask

    task automatic test_errors();
        int lat;
        send(1'b0, 32'h0000_0006, 32'h0);
        wait_resp(lat);
        checks++;
        if (lat != 3 || bus.resp_rdata !== 32'h0 || bus.resp_err !== 1'b1) begin
            failures++;
            $display("FAIL misaligned_read got lat=%0d rdata=%h err=%b exp 3/0/1", lat, bus.resp_rdata, bus.resp_err);
        end
        ack();
        send(1'b0, 32'h0000_0400, 32'h0);
        wait_resp(lat);
        checks++;
        if (lat != 3 || bus.resp_rdata !== 32'h0 || bus.resp_err !== 1'b1) begin
            failures++;
            $display("FAIL range_read got lat=%0d rdata=%h err=%b exp 3/0/1", lat, bus.resp_rdata, bus.resp_err);
        end
        ack();
        checks++;
        if (bus.resp_err !== 1'b0 || bus.resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL err_cleared got err=%b valid=%b exp 0/0", bus.resp_err, bus.resp_valid);
        end
        send(1'b1, 32'h0000_0005, 32'hBAD0_0001);
        wait_resp(lat);
        checks++;
        if (bus.resp_err !== 1'b1) begin
            failures++;
            $display("FAIL misaligned_write_err got=%b exp=1", bus.resp_err);
        end
        ack();
        send(1'b1, 32'h0000_0404, 32'hBAD0_0002);
        wait_resp(lat);
        ack();
        send(1'b0, 32'h0000_0004, 32'h0);
        wait_resp(lat);
        checks++;
        if (bus.resp_rdata !== 32'h0 || bus.resp_err !== 1'b0) begin
            failures++;
            $display("FAIL no_corruption got rdata=%h err=%b exp 0/0", bus.resp_rdata, bus.resp_err);
        end
        ack();
    endtask

    task automatic test_stall();
        int lat;
        int bad = 0;
        send(1'b1, 32'h0000_0014, 32'hCAFE_F00D);
        wait_resp(lat);
        ack();
        send(1'b0, 32'h0000_0014, 32'h0);
        wait_resp(lat);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 32'h0000_0014;
        bus.req_wdata = 32'h5555_AAAA;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'hCAFE_F00D || bus.resp_err !== 1'b0 || bus.req_ready !== 1'b0)
                bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL stall_hold got bad_cycles=%0d valid=%b rdata=%h ready=%b exp 0/1/cafef00d/0",
                     bad, bus.resp_valid, bus.resp_rdata, bus.req_ready);
        end
        bus.req_valid = 1'b0;
        ack();
        checks++;
        if (bus.resp_valid !== 1'b0 || bus.resp_rdata !== 32'h0) begin
            failures++;
            $display("FAIL resp_cleared got valid=%b rdata=%h exp 0/0", bus.resp_valid, bus.resp_rdata);
        end
        send(1'b0, 32'h0000_0014, 32'h0);
        wait_resp(lat);
        checks++;
        if (bus.resp_rdata !== 32'hCAFE_F00D) begin
            failures++;
            $display("FAIL stall_no_accept got rdata=%h exp=cafef00d", bus.resp_rdata);
        end
        ack();
    endtask

    task automatic test_reset_mid_wait();
        int lat;
        send(1'b1, 32'h0000_000C, 32'h1234_5678);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b0 || bus.resp_rdata !== 32'h0 || bus.resp_err !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_outputs got ready=%b valid=%b rdata=%h err=%b exp 0/0/0/0",
                     bus.req_ready, bus.resp_valid, bus.resp_rdata, bus.resp_err);
        end
        rst_n = 1'b1;
        send(1'b0, 32'h0000_000C, 32'h0);
        wait_resp(lat);
        checks++;
        if (lat != 3 || bus.resp_rdata !== 32'h0 || bus.resp_err !== 1'b0) begin
            failures++;
            $display("FAIL dropped_write got lat=%0d rdata=%h err=%b exp 3/0/0", lat, bus.resp_rdata, bus.resp_err);
        end
        ack();
        send(1'b0, 32'h0000_0008, 32'h0);
        wait_resp(lat);
        checks++;
        if (bus.resp_rdata !== 32'h0) begin
            failures++;
            $display("FAIL array_cleared got rdata=%h exp=0", bus.resp_rdata);
        end
        ack();
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [4] = '{32'h1111_0000, 32'h2222_0004, 32'h3333_0008, 32'h4444_000C};
        int n;
        bus0.resp_ready = 1'b1;
        bus0.req_valid  = 1'b1;
        for (int k = 0; k < 8; k++) begin
            bus0.req_write = (k < 4);
            bus0.req_addr  = 32'((k % 4) * 4);
            bus0.req_wdata = (k < 4) ? vals[k] : 32'h0;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!bus0.resp_valid && n < 20);
            checks++;
            if (n != ((k == 0) ? 1 : 2) || bus0.resp_err !== 1'b0 ||
                bus0.resp_rdata !== ((k < 4) ? 32'h0 : vals[k-4])) begin
                failures++;
                $display("FAIL b2b_%0d got gap=%0d rdata=%h err=%b exp %0d/%h/0", k, n, bus0.resp_rdata,
                         bus0.resp_err, (k == 0) ? 1 : 2, (k < 4) ? 32'h0 : vals[k-4]);
            end
        end
        bus0.req_valid = 1'b0;
        @(negedge clk);
        bus0.resp_ready = 1'b0;
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr = '0;
        bus.req_wdata = '0;
        bus.resp_ready = 1'b0;
        bus0.req_valid = 1'b0;
        bus0.req_write = 1'b0;
        bus0.req_addr = '0;
        bus0.req_wdata = '0;
        bus0.resp_ready = 1'b0;
        test_reset();
        test_write_read();
        test_errors();
        test_stall();
        test_reset_mid_wait();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
